pipeline_if_pcgen: RTL
======================

PIPELINE_IF_PCGEN -- requirements
Module: pipeline_if_pcgen

Interface
REQ-001 SHALL provide parameter: RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port: resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port: redirection_e_i  input  1  EXE-stage redirect request (branch mispredict or unpredicted jalr).
REQ-005 SHALL provide port: redirection_pc_e_i  input  32  EXE-stage corrected target.
REQ-006 SHALL provide port: taken_d_i  input  1  ID-stage static predictor taken.
REQ-007 SHALL provide port: prediction_pc_d_i  input  32  ID-stage predicted target.
REQ-008 SHALL provide port: st_f_i  input  1  IF stall from hazard unit.
REQ-009 SHALL provide port: imem_req_o  output  1  instruction memory request valid.
REQ-010 SHALL provide port: imem_addr_o  output  32  request address, word aligned.
REQ-011 SHALL provide port: imem_gnt_i  input  1  request accepted this cycle.
REQ-012 SHALL provide port: imem_rvalid_i  input  1  response data valid.
REQ-013 SHALL provide port: imem_rdata_i  input  32  response instruction.
REQ-014 SHALL provide port: instr_f_o  output  32  fetched instruction to ID.
REQ-015 SHALL provide port: pc_f_o  output  32  PC of instr_f_o.
REQ-016 SHALL provide port: pc_plus4_f_o  output  32  pc_f_o + 4.
REQ-017 SHALL provide port: instr_valid_f_o  output  1  instr_f_o holds a live instruction.

Function
REQ-018 SHALL run FSM states BOOT, REQ, WAIT, DROP; BOOT is entered only by reset and exits to REQ on the first clock after resetn rises.
REQ-019 SHALL hold imem_req_o=1 with imem_addr_o=next_pc in REQ; on imem_gnt_i move to WAIT and latch the request PC.
REQ-020 SHALL permit at most one outstanding request; no new request is issued while in WAIT or DROP.
REQ-021 SHALL, in WAIT, on imem_rvalid_i write imem_rdata_i and the latched PC into the output register (or the skid entry if the output register is held) and return to REQ.
REQ-022 SHALL select next_pc with priority: redirection_e_i -> redirection_pc_e_i & ~3; else taken_d_i -> prediction_pc_d_i & ~3; else latched PC + 4.
REQ-023 SHALL, when redirection_e_i=1 in WAIT before rvalid, enter DROP, discard the next response, then go to REQ at the redirect target; the redirect target is captured in a register.
REQ-024 SHALL, when redirection_e_i=1, clear instr_valid_f_o and the skid entry the next cycle, regardless of st_f_i.
REQ-025 SHALL, when taken_d_i=1, invalidate any fetched instruction younger than the branch (output register if not stalled, and the skid entry).
REQ-026 SHALL hold instr_f_o, pc_f_o, pc_plus4_f_o, instr_valid_f_o while st_f_i=1 (except REQ-024).
REQ-027 SHALL provide a 1-entry skid buffer that absorbs a response arriving while st_f_i=1; while it is full, no new request is issued; on stall release it moves to the output register in one cycle.
REQ-028 SHALL drive instr_f_o=32'h0000_0013 (nop) whenever instr_valid_f_o=0.
REQ-029 SHALL let a redirect coinciding with imem_gnt_i in REQ still send that request's response to DROP.
REQ-030 SHALL wrap all PC arithmetic modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
REQ-031 SHALL give a latency of 2 cycles from gnt with rvalid on the next cycle to instr_valid_f_o=1, with zero stall.

Reset
REQ-032 SHALL, on resetn=0 asynchronously: state=BOOT, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_f_o=0, instr_f_o=32'h13, pc_f_o=0, pc_plus4_f_o=0, skid empty, latched PC=RESET_PC-4.
REQ-033 SHALL, when reset is asserted mid-WAIT, drop the pending response; after release the first request address is RESET_PC.

Verification
REQ-034 SHALL cover sequential fetch: release reset, gnt and rvalid every cycle -> addresses 0x0, 0x4, 0x8; pc_f_o follows with pc_plus4_f_o = pc+4.
REQ-035 SHALL cover EXE redirect: redirection_e_i=1, pc=0x100 while WAIT on 0x8 -> 0x8 response dropped, next imem_addr_o=0x100, instr_valid_f_o low one cycle.
REQ-036 SHALL cover ID prediction: taken_d_i=1, prediction_pc=0x40 -> next request 0x40; redirect in the same cycle with 0x80 wins -> 0x80.
REQ-037 SHALL cover stall with skid: st_f_i=1 for 3 cycles while rvalid returns 0xC -> outputs held, no request while skid full, 0xC appears the cycle after release.
REQ-038 SHALL cover async reset mid-WAIT: resetn low between gnt and rvalid -> outputs reset immediately, late rvalid ignored, first request RESET_PC.
REQ-039 SHALL cover wrap-around: redirect to 0xFFFF_FFFC -> next sequential address 0x0000_0000.

Source files
------------

// File: rtl/pipeline_if_pcgen.sv
// Instruction-fetch PC generator: one outstanding imem request, EXE/ID redirection,
// a 1-entry skid buffer behind the IF output register, and nop insertion on bubbles.
module pipeline_if_pcgen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirection_e_i,
    input  logic [31:0] redirection_pc_e_i,
    input  logic        taken_d_i,
    input  logic [31:0] prediction_pc_d_i,
    input  logic        st_f_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_f_o,
    output logic [31:0] pc_f_o,
    output logic [31:0] pc_plus4_f_o,
    output logic        instr_valid_f_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] lat_pc_q, lat_pc_d;
    logic        out_v_q, out_v_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        flush_s;
    logic        grant_s;
    logic        accept_s;

    // Next-state computation for the fetch FSM, fetch address and delivery registers.
    always_comb begin
        flush_s      = redirection_e_i | taken_d_i;
        grant_s      = req_q & imem_gnt_i;
        // A taken ID branch makes the in-flight fetch wrong-path, exactly like an EXE redirect.
        accept_s     = (state_q == WAIT) & imem_rvalid_i & ~flush_s;

        state_d      = state_q;
        out_v_d      = out_v_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (grant_s) begin
                    state_d = flush_s ? DROP : WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = REQ;
                end else if (flush_s) begin
                    state_d = DROP;
                end else begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_d = REQ;
                end else begin
                    state_d = DROP;
                end
            end
            default: state_d = BOOT;
        endcase

        if (redirection_e_i) begin
            addr_d = {redirection_pc_e_i[31:2], 2'b00};
        end else if (taken_d_i) begin
            addr_d = {prediction_pc_d_i[31:2], 2'b00};
        end else if (grant_s) begin
            addr_d = addr_q + 32'd4;
        end else begin
            addr_d = addr_q;
        end

        if (grant_s) begin
            lat_pc_d = addr_q;
        end else begin
            lat_pc_d = lat_pc_q;
        end

        if (redirection_e_i) begin
            out_v_d     = 1'b0;
            out_instr_d = NOP;
            skid_v_d    = 1'b0;
        end else if (st_f_i) begin
            if (taken_d_i) begin
                skid_v_d = 1'b0;
            end else if (accept_s) begin
                skid_v_d     = 1'b1;
                skid_instr_d = imem_rdata_i;
                skid_pc_d    = lat_pc_q;
            end else begin
                skid_v_d = skid_v_q;
            end
        end else if (taken_d_i) begin
            out_v_d     = 1'b0;
            out_instr_d = NOP;
            skid_v_d    = 1'b0;
        end else if (skid_v_q) begin
            out_v_d     = 1'b1;
            out_instr_d = skid_instr_q;
            out_pc_d    = skid_pc_q;
            out_pc4_d   = skid_pc_q + 32'd4;
            skid_v_d    = 1'b0;
        end else if (accept_s) begin
            out_v_d     = 1'b1;
            out_instr_d = imem_rdata_i;
            out_pc_d    = lat_pc_q;
            out_pc4_d   = lat_pc_q + 32'd4;
        end else begin
            out_v_d     = 1'b0;
            out_instr_d = NOP;
        end

        req_d = (state_d == REQ) & ~skid_v_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= BOOT;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            lat_pc_q     <= RESET_PC - 32'd4;
            out_v_q      <= 1'b0;
            out_instr_q  <= NOP;
            out_pc_q     <= 32'h0000_0000;
            out_pc4_q    <= 32'h0000_0000;
            skid_v_q     <= 1'b0;
            skid_instr_q <= NOP;
            skid_pc_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            lat_pc_q     <= lat_pc_d;
            out_v_q      <= out_v_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_pc4_q    <= out_pc4_d;
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req_o      = req_q;
    assign imem_addr_o     = addr_q;
    assign instr_f_o       = out_instr_q;
    assign pc_f_o          = out_pc_q;
    assign pc_plus4_f_o    = out_pc4_q;
    assign instr_valid_f_o = out_v_q;

endmodule
